// File: rtl/s713_bist_ctrl.sv
// BIST controller for the s713 core: LFSR pattern source on the core inputs,
// MISR compaction of the core outputs, start/done handshake with pass/fail flag.
module s713_bist_ctrl #(
  parameter logic [15:0] N_PAT     = 16'd1024,
  parameter logic [7:0]  FLUSH_CYC = 8'd8,
  parameter logic [34:0] LFSR_SEED = 35'h1
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        START,
  input  logic [22:0] GOLDEN,
  input  logic [22:0] PO,
  output logic [34:0] PI,
  output logic        BUSY,
  output logic        DONE,
  output logic [22:0] SIG,
  output logic        PASS
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [34:0] SEED_EFF   = (LFSR_SEED == '0) ? 35'h1 : LFSR_SEED;
  localparam logic [15:0] FLUSH_LAST = {8'd0, FLUSH_CYC} - 16'd1;
  localparam logic [15:0] N_LAST     = N_PAT - 16'd1;

  state_e      state_q, state_d;
  logic [34:0] lfsr_q, lfsr_d;
  logic [22:0] misr_q, misr_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          lfsr_d  = SEED_EFF;
          misr_d  = '0;
          cnt_d   = '0;
          state_d = (FLUSH_CYC == 8'd0) ? S_RUN : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        // x^23+x^5+1: feedback from bit 22 enters at bits 0 and 5
        misr_d = {misr_q[21:0], misr_q[22]} ^ PO ^ {17'd0, misr_q[22], 5'd0};
        lfsr_d = {lfsr_q[33:0], lfsr_q[34] ^ lfsr_q[1]};
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == N_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!START) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PI   = (state_q == S_RUN) ? lfsr_q : '0;
    BUSY = (state_q == S_FLUSH) || (state_q == S_RUN);
    DONE = (state_q == S_DONE);
    SIG  = misr_q;
    PASS = (state_q == S_DONE) && (misr_q == GOLDEN);
  end

endmodule
